// File: rtl/lcd_bcd_writer.sv
// HD44780 8-bit writer: power-on delay, init command burst, then on request
// prints a sign character and DIGITS BCD digits with leading-zero blanking.
module lcd_bcd_writer #(
  parameter int DIGITS   = 10,
  parameter int E_CYCLES = 25,
  parameter int CMD_WAIT = 2500,
  parameter int CLR_WAIT = 100000,
  parameter int POR_WAIT = 750000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       sign,
  input  logic [3:0] bcd [DIGITS],
  output logic       ready,
  output logic       done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);
  localparam int MAX_A = (POR_WAIT > CLR_WAIT) ? POR_WAIT : CLR_WAIT;
  localparam int MAX_B = (CMD_WAIT > E_CYCLES) ? CMD_WAIT : E_CYCLES;
  localparam int MAXW  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAXW + 1);
  localparam int IW    = $clog2(DIGITS + 2);

  localparam logic [1:0] S_POR   = 2'd0;
  localparam logic [1:0] S_INIT  = 2'd1;
  localparam logic [1:0] S_IDLE  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  localparam logic [1:0] P_SETUP  = 2'd0;
  localparam logic [1:0] P_STROBE = 2'd1;
  localparam logic [1:0] P_WAIT   = 2'd2;

  localparam logic [CW-1:0] POR_LAST = CW'(POR_WAIT - 1);
  localparam logic [CW-1:0] E_LAST   = CW'(E_CYCLES - 1);
  localparam logic [CW-1:0] CMD_LAST = CW'(CMD_WAIT - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_WAIT - 1);
  localparam logic [IW-1:0] INIT_LAST  = IW'(3);
  localparam logic [IW-1:0] WRITE_LAST = IW'(DIGITS + 1);

  logic [1:0]    state, phase;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx, idx_n;
  logic          sign_q, lead;
  logic [3:0]    bcd_q [DIGITS];

  logic          nxt_rs, nxt_lead;
  logic [7:0]    nxt_data;
  logic [3:0]    dig;
  int            di;
  logic [CW-1:0] wait_last;
  logic          byte_last;

  assign lcd_rw = 1'b0;

  // Byte that will be driven next; in POR/IDLE this is the first byte of
  // the upcoming sequence, otherwise the one after the current byte.
  always_comb begin
    idx_n    = (state == S_INIT || state == S_WRITE) ? idx + 1'b1 : '0;
    nxt_rs   = 1'b0;
    nxt_data = 8'h00;
    nxt_lead = lead;
    dig      = 4'h0;
    di       = 0;
    if (state == S_POR || state == S_INIT) begin
      case (idx_n)
        IW'(0):  nxt_data = 8'h38;
        IW'(1):  nxt_data = 8'h0C;
        IW'(2):  nxt_data = 8'h06;
        default: nxt_data = 8'h01;
      endcase
    end else if (idx_n == IW'(0)) begin
      nxt_data = 8'h80;
    end else if (idx_n == IW'(1)) begin
      nxt_rs   = 1'b1;
      nxt_data = sign_q ? 8'h2D : 8'h20;
    end else begin
      nxt_rs = 1'b1;
      di     = DIGITS + 1 - int'(idx_n);
      for (int k = 0; k < DIGITS; k++)
        if (k == di) dig = bcd_q[k];
      // Units digit always prints, so an all-zero value still shows '0'.
      if (lead && dig == 4'h0 && di != 0) begin
        nxt_data = 8'h20;
      end else begin
        nxt_data = (dig < 4'd10) ? 8'h30 + {4'h0, dig} : 8'h3F;
        nxt_lead = 1'b0;
      end
    end
  end

  assign wait_last = (!lcd_rs && lcd_data == 8'h01) ? CLR_LAST : CMD_LAST;
  assign byte_last = (state == S_INIT) ? (idx == INIT_LAST) : (idx == WRITE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_POR;
      phase    <= P_SETUP;
      cnt      <= '0;
      idx      <= '0;
      sign_q   <= 1'b0;
      lead     <= 1'b0;
      bcd_q    <= '{default: 4'h0};
      ready    <= 1'b0;
      done     <= 1'b0;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
    end else begin
      done <= 1'b0;
      case (state)
        S_POR: begin
          if (cnt == POR_LAST) begin
            cnt      <= '0;
            state    <= S_INIT;
            phase    <= P_SETUP;
            idx      <= '0;
            lcd_rs   <= nxt_rs;
            lcd_data <= nxt_data;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (start) begin
            state    <= S_WRITE;
            ready    <= 1'b0;
            sign_q   <= sign;
            bcd_q    <= bcd;
            lead     <= 1'b1;
            phase    <= P_SETUP;
            idx      <= '0;
            cnt      <= '0;
            lcd_rs   <= nxt_rs;
            lcd_data <= nxt_data;
          end
        end
        default: begin
          case (phase)
            P_SETUP: begin
              lcd_e <= 1'b1;
              phase <= P_STROBE;
              cnt   <= '0;
            end
            P_STROBE: begin
              if (cnt == E_LAST) begin
                lcd_e <= 1'b0;
                phase <= P_WAIT;
                cnt   <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            default: begin
              if (cnt == wait_last) begin
                cnt <= '0;
                if (byte_last) begin
                  state <= S_IDLE;
                  ready <= 1'b1;
                  done  <= (state == S_WRITE);
                end else begin
                  idx      <= idx_n;
                  phase    <= P_SETUP;
                  lcd_rs   <= nxt_rs;
                  lcd_data <= nxt_data;
                  lead     <= nxt_lead;
                end
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          endcase
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_bcd_writer.sv
// Cycle-level bench for lcd_bcd_writer: expected LCD waveforms are built from
// a byte-list model of the display text and compared every clock.
module tb_lcd_bcd_writer;
  localparam int DIGITS = 4, E_CYCLES = 2, CMD_WAIT = 3, CLR_WAIT = 5, POR_WAIT = 10;
  typedef logic [3:0] bcd_t [DIGITS];
  typedef logic [8:0] bq_t [$];

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, sign = 1'b0;
  logic [3:0] bcd [DIGITS];
  logic       ready, done, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_data;
  int nerr = 0, nchk = 0;

  lcd_bcd_writer #(.DIGITS(DIGITS), .E_CYCLES(E_CYCLES), .CMD_WAIT(CMD_WAIT),
                   .CLR_WAIT(CLR_WAIT), .POR_WAIT(POR_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sign(sign), .bcd(bcd),
    .ready(ready), .done(done), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_e(lcd_e), .lcd_data(lcd_data));

  always #5 clk = ~clk;

  // Display text model: {rs, byte} list for one update.
  task automatic model_write(input logic s, input bcd_t b, output bq_t q);
    int top = 0;
    q = {};
    for (int i = 0; i < DIGITS; i++) if (b[i] != 0) top = i;
    q.push_back(9'h080);
    q.push_back(s ? 9'h12D : 9'h120);
    for (int i = DIGITS - 1; i >= 0; i--)
      if (i > top)      q.push_back(9'h120);
      else if (b[i] < 10) q.push_back({1'b1, 8'h30 + 8'(b[i])});
      else              q.push_back(9'h13F);
  endtask

  // Every clock of the byte sequence is compared: setup, E high, hold/wait.
  task automatic check_seq(input string nm, input bq_t q, input int disturb, input logic exp_done);
    int cyc = 0;
    bcd_t nb;
    foreach (q[j]) begin
      int w = (q[j] == 9'h001) ? CLR_WAIT : CMD_WAIT;
      for (int c = 0; c < 1 + E_CYCLES + w; c++) begin
        logic ee;
        @(negedge clk);
        ee = (c >= 1 && c <= E_CYCLES);
        nchk++;
        if ({lcd_e, lcd_rs, lcd_data, ready, done, lcd_rw} !== {ee, q[j], 1'b0, 1'b0, 1'b0}) begin
          nerr++;
          $display("FAIL %s byte%0d cyc%0d got e=%b rs=%b d=%h rdy=%b done=%b rw=%b exp e=%b rs=%b d=%h rdy=0 done=0 rw=0",
                   nm, j, c, lcd_e, lcd_rs, lcd_data, ready, done, lcd_rw, ee, q[j][8], q[j][7:0]);
        end
        if (cyc == disturb) begin
          for (int i = 0; i < DIGITS; i++) nb[i] = 4'($urandom_range(1, 15));
          bcd = nb; sign = ~sign; start = 1'b1;
        end else start = 1'b0;
        cyc++;
      end
    end
    @(negedge clk);
    nchk++;
    if ({ready, done} !== {1'b1, exp_done}) begin
      nerr++; $display("FAIL %s end got rdy=%b done=%b exp rdy=1 done=%b", nm, ready, done, exp_done);
    end
    @(negedge clk);
    nchk++;
    if ({ready, done} !== 2'b10) begin
      nerr++; $display("FAIL %s after got rdy=%b done=%b exp rdy=1 done=0", nm, ready, done);
    end
  endtask

  task automatic check_init(input string nm);
    bq_t q = '{9'h038, 9'h00C, 9'h006, 9'h001};
    for (int i = 0; i < POR_WAIT - 1; i++) begin
      @(negedge clk);
      nchk++;
      if ({lcd_e, ready, done} !== 3'b000) begin
        nerr++; $display("FAIL %s por cyc%0d got e=%b rdy=%b done=%b exp 000", nm, i, lcd_e, ready, done);
      end
    end
    check_seq(nm, q, -1, 1'b0);
  endtask

  task automatic do_start(input logic s, input bcd_t b);
    @(negedge clk);
    sign = s; bcd = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    nchk++;
    if ({ready, done, lcd_e, lcd_rs, lcd_rw, lcd_data} !== 13'h0) begin
      nerr++; $display("FAIL reset got rdy=%b done=%b e=%b rs=%b rw=%b d=%h exp all 0",
                       ready, done, lcd_e, lcd_rs, lcd_rw, lcd_data);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_init("init");
  endtask

  task automatic test_fixed(input string nm, input logic s, input bcd_t b, input int disturb);
    bq_t q;
    model_write(s, b, q);
    do_start(s, b);
    check_seq(nm, q, disturb, 1'b1);
  endtask

  task automatic test_random(input int n);
    bcd_t b;
    logic s;
    for (int t = 0; t < n; t++) begin
      s = 1'($urandom);
      for (int i = 0; i < DIGITS; i++) begin
        int r = $urandom_range(0, 9);
        b[i] = (r < 4) ? 4'h0 : (r < 7) ? 4'($urandom_range(1, 9)) : 4'($urandom_range(10, 15));
      end
      test_fixed("random", s, b, -1);
    end
  endtask

  task automatic test_mid_reset();
    bq_t q;
    bcd_t b = '{4'h3, 4'h2, 4'h1, 4'h9};
    model_write(1'b0, b, q);
    do_start(1'b0, b);
    repeat (3 * (1 + E_CYCLES + CMD_WAIT) + 2) @(negedge clk);
    nchk++;
    if ({lcd_e, lcd_rs, lcd_data} !== {1'b1, q[3]}) begin
      nerr++; $display("FAIL midrst pre got e=%b rs=%b d=%h exp e=1 rs=%b d=%h",
                       lcd_e, lcd_rs, lcd_data, q[3][8], q[3][7:0]);
    end
    rst_n = 1'b0;
    #1;
    nchk++;
    if ({lcd_e, ready, done, lcd_rs, lcd_data} !== 12'h0) begin
      nerr++; $display("FAIL midrst async got e=%b rdy=%b done=%b rs=%b d=%h exp all 0",
                       lcd_e, ready, done, lcd_rs, lcd_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_init("reinit");
  endtask

  initial begin
    bcd = '{default: 4'h0};
    test_reset();
    test_fixed("neg123", 1'b1, '{4'h3, 4'h2, 4'h1, 4'h0}, -1);
    test_fixed("zero", 1'b0, '{4'h0, 4'h0, 4'h0, 4'h0}, -1);
    test_fixed("bad_digit", 1'b0, '{4'h5, 4'h0, 4'hB, 4'h0}, -1);
    test_fixed("full", 1'b1, '{4'h9, 4'h8, 4'h7, 4'h6}, -1);
    test_fixed("ignored_start", 1'b0, '{4'h7, 4'h0, 4'h0, 4'h0}, 8);
    test_random(6);
    test_mid_reset();
    test_fixed("after_rst", 1'b1, '{4'h0, 4'hF, 4'h0, 4'h0}, -1);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
